// File: rtl/run_monitor_pkg.sv
// Shared types and constants for the run monitor.
//   state_t   : dump/run FSM states
//   cause_t   : halt cause codes (0 none, 1 address, 2 stuck PC, 3 external)
//   HDR_MAGIC : top byte of the dump header word
//   hdr_word  : builds the 32-bit header {magic, 6'b0, cause, nregs[15:0]}
package run_monitor_pkg;

  typedef enum logic [2:0] {
    ST_RUN  = 3'd0,
    ST_HDR  = 3'd1,
    ST_RD   = 3'd2,
    ST_SEND = 3'd3,
    ST_PCW  = 3'd4,
    ST_CYCW = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'd0,
    CAUSE_ADDR  = 2'd1,
    CAUSE_STUCK = 2'd2,
    CAUSE_EXT   = 2'd3
  } cause_t;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;

  function automatic logic [31:0] hdr_word(input logic [1:0] cause, input int unsigned nregs);
    return {HDR_MAGIC, 6'b0, cause, 16'(nregs)};
  endfunction

endpackage

// File: rtl/run_monitor_detect.sv
// Halt-event detection for the run monitor.
//   i_clk, i_rst      : clock, synchronous active-low reset
//   i_pc, i_pc_valid  : retiring PC and its valid strobe
//   i_halt_addr/en    : NUM_HALT packed address comparators with enables
//   i_halt_req        : external halt request
//   i_active          : monitor is in RUN; events and tracking only count here
//   i_clear           : clears stuck-PC tracking (rearm)
//   o_hit, o_cause    : combinational hit and prioritised cause
//                       (address > stuck > external)
module run_monitor_detect
  import run_monitor_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int NUM_HALT    = 2,
  parameter int STALL_LIMIT = 1024
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [XLEN-1:0]          i_pc,
  input  logic                     i_pc_valid,
  input  logic [NUM_HALT*XLEN-1:0] i_halt_addr,
  input  logic [NUM_HALT-1:0]      i_halt_en,
  input  logic                     i_halt_req,
  input  logic                     i_active,
  input  logic                     i_clear,
  output logic                     o_hit,
  output logic [1:0]               o_cause
);

  localparam int CNT_W = $clog2(STALL_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(STALL_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STALL_LIMIT);

  logic [XLEN-1:0]  last_pc;
  logic             have_last;
  logic [CNT_W-1:0] run_cnt;   // length of the current run of identical retires
  logic             addr_hit;
  logic             same_pc;
  logic             stuck_hit;
  logic             ext_hit;

  always_comb begin
    addr_hit = 1'b0;
    for (int k = 0; k < NUM_HALT; k++) begin
      if (i_halt_en[k] && (i_pc == i_halt_addr[k*XLEN +: XLEN])) addr_hit = 1'b1;
    end
    addr_hit = addr_hit && i_pc_valid && i_active;
  end

  assign same_pc   = have_last && (i_pc == last_pc);
  // This retire would be the STALL_LIMIT-th identical one in a row.
  assign stuck_hit = i_active && i_pc_valid && same_pc && (run_cnt == CNT_FIRE);
  assign ext_hit   = i_active && i_halt_req;
  assign o_hit     = addr_hit || stuck_hit || ext_hit;

  always_comb begin
    o_cause = CAUSE_NONE;
    if (addr_hit)       o_cause = CAUSE_ADDR;
    else if (stuck_hit) o_cause = CAUSE_STUCK;
    else if (ext_hit)   o_cause = CAUSE_EXT;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst || i_clear) begin
      last_pc   <= '0;
      have_last <= 1'b0;
      run_cnt   <= '0;
    end else if (i_active && i_pc_valid) begin
      last_pc   <= i_pc;
      have_last <= 1'b1;
      if (!same_pc)                run_cnt <= CNT_W'(1);
      else if (run_cnt != CNT_MAX) run_cnt <= run_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/run_monitor.sv
// Run monitor: counts cycles while the CPU runs, halts it on an address match,
// a stuck PC or an external request, then streams a dump:
//   header, registers 0..NREGS-1, captured PC, cycle count (NREGS+3 words).
// Ports:
//   i_clk, i_rst            : clock, synchronous active-low reset
//   i_pc, i_pc_valid        : retiring PC
//   i_halt_addr, i_halt_en  : packed halt-address comparators and enables
//   i_halt_req              : external halt request
//   i_rearm                 : leave DONE and resume RUN
//   o_reg_addr, i_reg_data  : register-file read port (data one cycle after addr)
//   o_tx_data/o_tx_valid/i_tx_ready : dump stream; a word moves on valid && ready,
//                             data and valid hold while valid && !ready
//   o_halt, o_cause, o_cycles, o_done : status
//   o_state                 : current FSM state (debug)
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int NUM_HALT    = 2,
  parameter int NREGS       = 32,
  parameter int STALL_LIMIT = 1024,
  parameter int CYCLE_W     = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [XLEN-1:0]          i_pc,
  input  logic                     i_pc_valid,
  input  logic [NUM_HALT*XLEN-1:0] i_halt_addr,
  input  logic [NUM_HALT-1:0]      i_halt_en,
  input  logic                     i_halt_req,
  input  logic                     i_rearm,
  output logic [$clog2(NREGS)-1:0] o_reg_addr,
  input  logic [XLEN-1:0]          i_reg_data,
  output logic [XLEN-1:0]          o_tx_data,
  output logic                     o_tx_valid,
  input  logic                     i_tx_ready,
  output logic                     o_halt,
  output logic [1:0]               o_cause,
  output logic [CYCLE_W-1:0]       o_cycles,
  output logic                     o_done,
  output logic [2:0]               o_state
);

  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] LAST_REG = AW'(NREGS - 1);

  state_t          state;
  logic [XLEN-1:0] cap_pc;
  logic            det_hit;
  logic [1:0]      det_cause;
  logic            active;
  logic            clear;

  assign active  = (state == ST_RUN);
  assign clear   = (state == ST_DONE) && i_rearm;
  assign o_state = state;

  run_monitor_detect #(
    .XLEN        (XLEN),
    .NUM_HALT    (NUM_HALT),
    .STALL_LIMIT (STALL_LIMIT)
  ) u_detect (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_pc        (i_pc),
    .i_pc_valid  (i_pc_valid),
    .i_halt_addr (i_halt_addr),
    .i_halt_en   (i_halt_en),
    .i_halt_req  (i_halt_req),
    .i_active    (active),
    .i_clear     (clear),
    .o_hit       (det_hit),
    .o_cause     (det_cause)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state      <= ST_RUN;
      o_halt     <= 1'b0;
      o_done     <= 1'b0;
      o_cause    <= CAUSE_NONE;
      o_cycles   <= '0;
      o_tx_valid <= 1'b0;
      o_tx_data  <= '0;
      o_reg_addr <= '0;
      cap_pc     <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (o_cycles != '1) o_cycles <= o_cycles + CYCLE_W'(1);
          if (det_hit) begin
            // Header is loaded here so it is already valid in the HDR cycle.
            state      <= ST_HDR;
            o_halt     <= 1'b1;
            o_cause    <= det_cause;
            cap_pc     <= i_pc;
            o_tx_data  <= XLEN'(hdr_word(det_cause, NREGS));
            o_tx_valid <= 1'b1;
            o_reg_addr <= '0;
          end
        end
        ST_HDR: begin
          if (i_tx_ready) begin
            o_tx_valid <= 1'b0;
            state      <= ST_RD;
          end
        end
        ST_RD: begin
          // o_reg_addr is presented this cycle; data appears in SEND.
          state <= ST_SEND;
        end
        ST_SEND: begin
          if (!o_tx_valid) begin
            o_tx_data  <= i_reg_data;
            o_tx_valid <= 1'b1;
          end else if (i_tx_ready) begin
            if (o_reg_addr == LAST_REG) begin
              o_tx_data <= cap_pc;
              state     <= ST_PCW;
            end else begin
              o_tx_valid <= 1'b0;
              o_reg_addr <= o_reg_addr + AW'(1);
              state      <= ST_RD;
            end
          end
        end
        ST_PCW: begin
          if (i_tx_ready) begin
            o_tx_data <= XLEN'(o_cycles);
            state     <= ST_CYCW;
          end
        end
        ST_CYCW: begin
          if (i_tx_ready) begin
            o_tx_valid <= 1'b0;
            o_done     <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (i_rearm) begin
            state      <= ST_RUN;
            o_halt     <= 1'b0;
            o_done     <= 1'b0;
            o_cycles   <= '0;
            o_cause    <= CAUSE_NONE;
            o_reg_addr <= '0;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_run_monitor.sv
`timescale 1ns/1ps
module tb_run_monitor;
  import run_monitor_pkg::*;

  localparam int XLEN        = 32;
  localparam int NUM_HALT    = 2;
  localparam int NREGS       = 32;
  localparam int STALL_LIMIT = 4;
  localparam int CYCLE_W     = 32;
  localparam int AW          = $clog2(NREGS);

  // ---------------- clock / reset / DUT ----------------
  logic                     i_clk       = 1'b0;
  logic                     i_rst       = 1'b0;
  logic [XLEN-1:0]          i_pc        = '0;
  logic                     i_pc_valid  = 1'b0;
  logic [NUM_HALT*XLEN-1:0] i_halt_addr = '0;
  logic [NUM_HALT-1:0]      i_halt_en   = '0;
  logic                     i_halt_req  = 1'b0;
  logic                     i_rearm     = 1'b0;
  logic [AW-1:0]            o_reg_addr;
  logic [XLEN-1:0]          i_reg_data  = '0;
  logic [XLEN-1:0]          o_tx_data;
  logic                     o_tx_valid;
  logic                     i_tx_ready  = 1'b1;
  logic                     o_halt;
  logic [1:0]               o_cause;
  logic [CYCLE_W-1:0]       o_cycles;
  logic                     o_done;
  logic [2:0]               o_state;

  always #5 i_clk = ~i_clk;

  run_monitor #(
    .XLEN(XLEN), .NUM_HALT(NUM_HALT), .NREGS(NREGS),
    .STALL_LIMIT(STALL_LIMIT), .CYCLE_W(CYCLE_W)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_pc(i_pc), .i_pc_valid(i_pc_valid),
    .i_halt_addr(i_halt_addr), .i_halt_en(i_halt_en), .i_halt_req(i_halt_req),
    .i_rearm(i_rearm), .o_reg_addr(o_reg_addr), .i_reg_data(i_reg_data),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .o_halt(o_halt), .o_cause(o_cause), .o_cycles(o_cycles), .o_done(o_done),
    .o_state(o_state)
  );

  // ---------------- reference model state ----------------
  logic [XLEN-1:0] rf[NREGS];          // register file contents
  logic [XLEN-1:0] ha[NUM_HALT];       // halt addresses
  logic            he[NUM_HALT];       // halt enables
  logic [XLEN-1:0] hist[$];            // valid retires since reset/rearm
  int              run_cnt;            // RUN cycles since reset/rearm
  logic [XLEN-1:0] exp_q[$];           // scoreboard: expected dump words
  int              words_seen;
  int              n_tests = 0;
  int              n_fail  = 0;
  logic            rand_ready = 1'b0;
  logic            stall_prev = 1'b0;
  logic [XLEN-1:0] stall_data = '0;

  // Synchronous-read register file.
  always @(posedge i_clk) i_reg_data <= rf[o_reg_addr];

  // Backpressure source.
  always @(posedge i_clk) begin
    #1;
    i_tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Stream monitor: scoreboard and hold-under-backpressure check.
  always @(negedge i_clk) begin
    logic [XLEN-1:0] exp_w;
    if (i_rst && stall_prev) begin
      n_tests++;
      assert (o_tx_valid === 1'b1 && o_tx_data === stall_data) else begin
        n_fail++;
        $error("FAIL tx_hold: observed valid=%0b data=%h expected valid=1 data=%h",
               o_tx_valid, o_tx_data, stall_data);
      end
    end
    stall_prev = i_rst && o_tx_valid && !i_tx_ready;
    stall_data = o_tx_data;
    if (i_rst && o_tx_valid === 1'b1 && i_tx_ready) begin
      n_tests++;
      words_seen++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $error("FAIL extra_word: observed %h expected no word", o_tx_data);
      end else begin
        exp_w = exp_q.pop_front();
        assert (o_tx_data === exp_w) else begin
          n_fail++;
          $error("FAIL dump_word[%0d]: observed %h expected %h", words_seen - 1, o_tx_data, exp_w);
        end
      end
    end
  end

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    n_tests++;
    n_fail++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  task automatic set_halt(input int k, input logic [XLEN-1:0] addr, input logic en);
    ha[k] = addr;
    he[k] = en;
    i_halt_addr[k*XLEN +: XLEN] = addr;
    i_halt_en[k] = en;
  endtask

  task automatic fill_rf();
    for (int i = 0; i < NREGS; i++) rf[i] = $urandom;
  endtask

  task automatic clear_model();
    hist.delete();
    exp_q.delete();
    run_cnt = 0;
  endtask

  // One RUN cycle: predicts the outcome from the rules, drives, then checks.
  task automatic run_cycle(input logic [XLEN-1:0] pc, input logic v, input logic req,
                           output logic hit);
    logic a_hit, s_hit;
    logic [1:0] cause;
    int trail;
    a_hit = 1'b0;
    s_hit = 1'b0;
    for (int k = 0; k < NUM_HALT; k++)
      if (v && he[k] && pc == ha[k]) a_hit = 1'b1;
    if (v) begin
      trail = 1;
      for (int i = hist.size() - 1; i >= 0; i--) begin
        if (hist[i] != pc) break;
        trail++;
      end
      s_hit = (trail >= STALL_LIMIT);
      hist.push_back(pc);
    end
    hit   = a_hit || s_hit || req;
    cause = a_hit ? 2'd1 : s_hit ? 2'd2 : req ? 2'd3 : 2'd0;
    run_cnt++;
    i_pc = pc; i_pc_valid = v; i_halt_req = req;
    @(posedge i_clk); #1;
    i_pc_valid = 1'b0; i_halt_req = 1'b0;
    chk("halt", o_halt, hit);
    if (hit) begin
      chk("cause", o_cause, cause);
      chk("cycles_at_halt", o_cycles, run_cnt);
      chk("state_hdr", o_state, ST_HDR);
      words_seen = 0;
      exp_q.push_back({8'hA5, 6'b0, cause, 16'(NREGS)});
      for (int i = 0; i < NREGS; i++) exp_q.push_back(rf[i]);
      exp_q.push_back(pc);
      exp_q.push_back(XLEN'(run_cnt));
    end
  endtask

  task automatic wait_dump_done();
    int n;
    n = 0;
    while (o_done !== 1'b1 && n < 3000) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (n >= 3000) fail_now("dump_timeout");
    chk("done_flag", o_done, 1'b1);
    chk("halt_in_done", o_halt, 1'b1);
    chk("txv_in_done", o_tx_valid, 1'b0);
    chk("words_left", exp_q.size(), 0);
    chk("word_count", words_seen, NREGS + 3);
  endtask

  task automatic do_rearm();
    i_rearm = 1'b1;
    @(posedge i_clk); #1;
    i_rearm = 1'b0;
    chk("rearm_state", o_state, ST_RUN);
    chk("rearm_halt", o_halt, 1'b0);
    chk("rearm_done", o_done, 1'b0);
    chk("rearm_cycles", o_cycles, 0);
    chk("rearm_cause", o_cause, 0);
    clear_model();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"}, o_state, ST_RUN);
    chk({tag, "_halt"}, o_halt, 1'b0);
    chk({tag, "_done"}, o_done, 1'b0);
    chk({tag, "_cause"}, o_cause, 0);
    chk({tag, "_cycles"}, o_cycles, 0);
    chk({tag, "_txv"}, o_tx_valid, 1'b0);
    chk({tag, "_txd"}, o_tx_data, 0);
    chk({tag, "_raddr"}, o_reg_addr, 0);
  endtask

  // Overall time bound.
  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic hit;
    int n;
    logic [XLEN-1:0] pcs[4];
    pcs[0] = 32'h40; pcs[1] = 32'h44; pcs[2] = 32'h2000; pcs[3] = 32'h3000;

    clear_model();
    fill_rf();
    set_halt(0, 32'h2000, 1'b1);
    set_halt(1, 32'h3000, 1'b0);

    // Reset values.
    i_rst = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check_reset_values("reset");
    i_rst = 1'b1;

    // Address hit on the 10th RUN cycle; 35-word dump without backpressure.
    for (int c = 0; c < 9; c++) run_cycle(32'h0, 1'b0, 1'b0, hit);
    run_cycle(32'h2000, 1'b1, 1'b0, hit);
    chk("addr_hit_cause", o_cause, 2'd1);
    chk("addr_hit_cycles", o_cycles, 10);
    wait_dump_done();
    do_rearm();

    // Stuck PC with backpressure; disabled comparator stays silent.
    fill_rf();
    rand_ready = 1'b1;
    for (int c = 0; c < 6; c++) run_cycle((c % 2) ? 32'h3000 : 32'h3004, 1'b1, 1'b0, hit);
    run_cnt = run_cnt;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 10) begin
      run_cycle(32'h40, 1'b1, 1'b0, hit);
      n++;
    end
    chk("stuck_retires", n, STALL_LIMIT);
    chk("stuck_cause", o_cause, 2'd2);
    wait_dump_done();
    do_rearm();

    // Address, stuck and external in the same cycle: address wins.
    fill_rf();
    set_halt(0, 32'h2000, 1'b0);
    for (int c = 0; c < STALL_LIMIT - 1; c++) run_cycle(32'h2000, 1'b1, 1'b0, hit);
    set_halt(0, 32'h2000, 1'b1);
    run_cycle(32'h2000, 1'b1, 1'b1, hit);
    chk("prio_cause", o_cause, 2'd1);
    wait_dump_done();

    // Random rounds; rearm pulses while running must be ignored.
    for (int r = 0; r < 4; r++) begin
      do_rearm();
      fill_rf();
      set_halt(0, pcs[$urandom_range(0, 3)], 1'($urandom_range(0, 1)));
      set_halt(1, pcs[$urandom_range(0, 3)], 1'($urandom_range(0, 1)));
      hit = 1'b0;
      n = 0;
      while (!hit && n < 200) begin
        i_rearm = ($urandom_range(0, 9) == 0);
        run_cycle(pcs[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 49) == 0), hit);
        i_rearm = 1'b0;
        n++;
      end
      if (!hit) run_cycle(32'h0, 1'b0, 1'b1, hit);
      wait_dump_done();
    end

    // Reset in the middle of a dump.
    do_rearm();
    fill_rf();
    rand_ready = 1'b0;
    run_cycle(32'h500, 1'b0, 1'b1, hit);
    n = 0;
    while (words_seen < 5 && n < 200) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (n >= 200) fail_now("mid_dump_wait");
    i_rst = 1'b0;
    clear_model();
    @(posedge i_clk); #1;
    check_reset_values("mid_reset");
    i_rst = 1'b1;
    n = words_seen;
    for (int c = 0; c < 20; c++) run_cycle(32'h0, 1'b0, 1'b0, hit);
    chk("no_words_after_reset", words_seen, n);
    chk("cycles_after_reset", o_cycles, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
